// File: rtl/audio_sample_sched.sv
// rtl/audio_sample_sched.sv - paced stereo sample scheduler with priming, underrun recovery and soft mute
//
// Buffers stereo PCM pairs from the core in a small FIFO and releases exactly
// one pair per output-rate tick (48/96 kHz derived fractionally from clk), so
// the downstream audio_out sees a steady, rate-correct stream.
//
// Ports:
//   clk, reset_n            system clock, asynchronous active-low reset
//   sample_rate             0 = 48 kHz tick, 1 = 96 kHz tick
//   in_valid / in_ready     source handshake; in_left/in_right signed PCM
//   mute                    level request for a 16-tick soft-mute ramp
//   out_left / out_right    registered, gain-scaled PCM to audio_out
//   out_strobe              1-cycle pulse when out_left/out_right update
//   underrun                1-cycle pulse on a RUN tick that found the FIFO empty
//   level                   current FIFO occupancy (0..FIFO_DEPTH)

module audio_sample_sched #(
    parameter int CLK_RATE   = 50000000,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            sample_rate,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [15:0]                     in_left,
    input  logic [15:0]                     in_right,
    input  logic                            mute,
    output logic [15:0]                     out_left,
    output logic [15:0]                     out_right,
    output logic                            out_strobe,
    output logic                            underrun,
    output logic [$clog2(FIFO_DEPTH):0]     level
);

    localparam int              AW       = $clog2(FIFO_DEPTH);
    localparam int              LW       = AW + 1;
    localparam logic [LW-1:0]   DEPTH_L  = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0]   HALF_L   = LW'(FIFO_DEPTH / 2);
    localparam logic [32:0]     CLK_L    = 33'(CLK_RATE);
    localparam logic [32:0]     INC_48K  = 33'd48000;
    localparam logic [32:0]     INC_96K  = 33'd96000;
    localparam logic [4:0]      GAIN_MAX = 5'd16;

    typedef enum logic {
        S_PRIME = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Fractional tick generator. The accumulator keeps its phase across
    // rate changes; a change only alters the increment used next.
    // ------------------------------------------------------------------
    logic [31:0] acc;
    logic [32:0] acc_sum;
    logic        tick;

    always_comb begin
        acc_sum = {1'b0, acc} + (sample_rate ? INC_96K : INC_48K);
        tick    = (acc_sum >= CLK_L);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc <= 32'd0;
        end else if (tick) begin
            acc <= 32'(acc_sum - CLK_L);
        end else begin
            acc <= acc_sum[31:0];
        end
    end

    // ------------------------------------------------------------------
    // FIFO. in_ready comes from the registered level, so a full FIFO
    // refuses a push even when a pop happens in the same cycle.
    // ------------------------------------------------------------------
    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic [31:0]   head;

    assign in_ready = (level < DEPTH_L);
    assign push     = in_valid && in_ready;
    assign head     = mem[rd_ptr];

    // Storage needs no reset: pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_left, in_right};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Scheduler FSM. PRIME holds off pops until the FIFO is half full so
    // a brief source stall does not immediately underrun again.
    // ------------------------------------------------------------------
    state_t state;
    state_t state_d;
    logic   tick_underrun;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_PRIME;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d       = state;
        pop           = 1'b0;
        tick_underrun = 1'b0;
        case (state)
            S_PRIME: begin
                if (level >= HALF_L) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (tick) begin
                    if (level != '0) begin
                        pop = 1'b1;
                    end else begin
                        tick_underrun = 1'b1;
                        state_d       = S_PRIME;
                    end
                end
            end
            default: state_d = S_PRIME;
        endcase
    end

    // ------------------------------------------------------------------
    // Output path and soft-mute gain. The sample emitted on a tick uses
    // the gain value from before that tick's ramp step.
    // ------------------------------------------------------------------
    logic [4:0]  gain;
    logic [15:0] held_left;
    logic [15:0] held_right;
    logic [15:0] src_left;
    logic [15:0] src_right;

    function automatic logic [15:0] scale(input logic [15:0] s, input logic [4:0] g);
        logic signed [20:0] prod;
        prod  = $signed({{5{s[15]}}, s}) * $signed({16'd0, g});
        scale = 16'(prod >>> 4);
    endfunction

    always_comb begin
        src_left  = held_left;
        src_right = held_right;
        if (pop) begin
            src_left  = head[31:16];
            src_right = head[15:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gain       <= 5'd0;
            held_left  <= 16'd0;
            held_right <= 16'd0;
            out_left   <= 16'd0;
            out_right  <= 16'd0;
            out_strobe <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            out_strobe <= tick;
            underrun   <= tick_underrun;
            if (pop) begin
                held_left  <= head[31:16];
                held_right <= head[15:0];
            end
            if (tick) begin
                out_left  <= scale(src_left, gain);
                out_right <= scale(src_right, gain);
                if (mute) begin
                    if (gain != 5'd0) begin
                        gain <= gain - 5'd1;
                    end
                end else if (gain < GAIN_MAX) begin
                    gain <= gain + 5'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_audio_sample_sched.sv
// tb/tb_audio_sample_sched.sv - scoreboard bench for audio_sample_sched

module tb_audio_sample_sched;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sample_rate;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_left;
    logic [15:0] in_right;
    logic        mute;
    logic [15:0] out_left;
    logic [15:0] out_right;
    logic        out_strobe;
    logic        underrun;
    logic [3:0]  level;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // expected {underrun, out_left, out_right} per strobe
    logic [32:0] exp_q[$];

    audio_sample_sched #(
        .CLK_RATE   (480000),
        .FIFO_DEPTH (8)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sample_rate (sample_rate),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_left     (in_left),
        .in_right    (in_right),
        .mute        (mute),
        .out_left    (out_left),
        .out_right   (out_right),
        .out_strobe  (out_strobe),
        .underrun    (underrun),
        .level       (level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares each strobe against the scoreboard when expectations are queued.
    initial begin
        logic [32:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (out_strobe) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("strobe_out", {31'd0, underrun, out_left, out_right}, {31'd0, e});
                end
            end else if (underrun) begin
                check("underrun_without_strobe", {63'd0, underrun}, 64'd0);
            end
        end
    end

    function automatic logic [32:0] ex(input logic u, input logic [15:0] l, input logic [15:0] r);
        return {u, l, r};
    endfunction

    function automatic logic [32:0] ramp(input int g);
        logic [15:0] l;
        l = 16'(g * 1024);
        return {1'b0, l, 16'(-g * 1024)};
    endfunction

    task automatic wait_strobe(output int t);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_strobe && n < 40);
        check("strobe_seen", {63'd0, out_strobe}, 64'd1);
        t = cyc;
    endtask

    task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
        in_left  = l;
        in_right = r;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int t0, t1, t2, t3, t4, t5, t6, tx;
        reset_n     = 1'b0;
        sample_rate = 1'b0;
        in_valid    = 1'b0;
        in_left     = 16'd0;
        in_right    = 16'd0;
        mute        = 1'b0;
        #1;
        check("rst_out_left",   {48'd0, out_left},   64'd0);
        check("rst_out_right",  {48'd0, out_right},  64'd0);
        check("rst_out_strobe", {63'd0, out_strobe}, 64'd0);
        check("rst_underrun",   {63'd0, underrun},   64'd0);
        check("rst_level",      {60'd0, level},      64'd0);
        check("rst_in_ready",   {63'd0, in_ready},   64'd1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Tick spacing: 10 cycles at 48k, 5 at 96k, no phase glitch across switches.
        wait_strobe(t0);
        wait_strobe(t1);
        wait_strobe(t2);
        check("tick48_a", 64'(t1 - t0), 64'd10);
        check("tick48_b", 64'(t2 - t1), 64'd10);
        sample_rate = 1'b1;
        wait_strobe(t3);
        wait_strobe(t4);
        wait_strobe(t5);
        check("tick96_switch", 64'(t3 - t2), 64'd5);
        check("tick96_a",      64'(t4 - t3), 64'd5);
        check("tick96_b",      64'(t5 - t4), 64'd5);
        sample_rate = 1'b0;
        wait_strobe(t6);
        check("tick48_back", 64'(t6 - t5), 64'd10);

        // Let gain ramp to 16 while priming with a zero held pair.
        for (int i = 0; i < 12; i++) exp_q.push_back(ex(1'b0, 16'h0000, 16'h0000));
        for (int i = 0; i < 12; i++) wait_strobe(tx);

        // Priming, order, pass-through and underrun recovery.
        exp_q.push_back(ex(1'b0, 16'h0000, 16'h0000));
        exp_q.push_back(ex(1'b0, 16'h7FFF, 16'h8000));
        exp_q.push_back(ex(1'b0, 16'h1234, 16'hFEDC));
        exp_q.push_back(ex(1'b0, 16'h8001, 16'h0001));
        exp_q.push_back(ex(1'b0, 16'h5A5A, 16'hA5A5));
        exp_q.push_back(ex(1'b1, 16'h5A5A, 16'hA5A5));
        exp_q.push_back(ex(1'b0, 16'h5A5A, 16'hA5A5));
        for (int i = 1; i <= 4; i++) exp_q.push_back(ex(1'b0, 16'(16'h1000 + i), 16'(16'hF000 + i)));
        exp_q.push_back(ex(1'b1, 16'h1004, 16'hF004));
        push_pair(16'h7FFF, 16'h8000);
        push_pair(16'h1234, 16'hFEDC);
        push_pair(16'h8001, 16'h0001);
        check("prime_level3", {60'd0, level}, 64'd3);
        wait_strobe(tx);
        push_pair(16'h5A5A, 16'hA5A5);
        check("prime_level4", {60'd0, level}, 64'd4);
        for (int i = 0; i < 5; i++) wait_strobe(tx);
        for (int i = 1; i <= 3; i++) push_pair(16'(16'h1000 + i), 16'(16'hF000 + i));
        wait_strobe(tx);
        check("reprime_no_pop", {60'd0, level}, 64'd3);
        push_pair(16'h1004, 16'hF004);
        for (int i = 0; i < 5; i++) wait_strobe(tx);

        // Full FIFO refuses a 9th push; push+pop at level 5 keeps level.
        for (int i = 0; i <= 8; i++) exp_q.push_back(ex(1'b0, 16'(16'h2100 + i), 16'(16'hD100 + i)));
        exp_q.push_back(ex(1'b1, 16'h2108, 16'hD108));
        for (int i = 0; i < 9; i++) begin
            if (i < 8) begin
                in_left  = 16'(16'h2100 + i);
                in_right = 16'(16'hD100 + i);
            end else begin
                in_left  = 16'hDEAD;
                in_right = 16'hBEEF;
                check("full_in_ready", {63'd0, in_ready}, 64'd0);
            end
            in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("full_level8", {60'd0, level}, 64'd8);
        wait_strobe(tx);
        check("pop_level7", {60'd0, level}, 64'd7);
        wait_strobe(tx);
        wait_strobe(tx);
        check("pop_level5", {60'd0, level}, 64'd5);
        repeat (9) @(posedge clk);
        @(negedge clk);
        in_left  = 16'h2108;
        in_right = 16'hD108;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("pushpop_level5", {60'd0, level}, 64'd5);
        check("pushpop_strobe", {63'd0, out_strobe}, 64'd1);
        for (int i = 0; i < 6; i++) wait_strobe(tx);

        // Soft mute ramp on a held 0x4000 / 0xC000 pair.
        for (int i = 0; i < 4; i++) exp_q.push_back(ex(1'b0, 16'h4000, 16'hC000));
        exp_q.push_back(ex(1'b1, 16'h4000, 16'hC000));
        for (int i = 0; i < 4; i++) push_pair(16'h4000, 16'hC000);
        for (int i = 0; i < 5; i++) wait_strobe(tx);
        mute = 1'b1;
        for (int g = 16; g >= 0; g--) exp_q.push_back(ramp(g));
        for (int i = 0; i < 17; i++) wait_strobe(tx);
        mute = 1'b0;
        for (int g = 0; g <= 16; g++) exp_q.push_back(ramp(g));
        for (int i = 0; i < 17; i++) wait_strobe(tx);
        mute = 1'b1;
        for (int g = 16; g >= 14; g--) exp_q.push_back(ramp(g));
        for (int i = 0; i < 3; i++) wait_strobe(tx);
        repeat (3) @(negedge clk);
        check("pre_reset_left", {48'd0, out_left}, 64'h3800);
        reset_n = 1'b0;
        #1;
        check("async_rst_left",  {48'd0, out_left},  64'd0);
        check("async_rst_right", {48'd0, out_right}, 64'd0);
        check("async_rst_level", {60'd0, level},     64'd0);
        check("async_rst_ready", {63'd0, in_ready},  64'd1);
        @(negedge clk);
        reset_n = 1'b1;
        mute    = 1'b0;
        exp_q.push_back(ex(1'b0, 16'h0000, 16'h0000));
        wait_strobe(tx);
        @(posedge clk);
        #2;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/audio_sample_sched.md
# audio_sample_sched

Sample scheduler and output controller placed in front of `audio_out`. Accepts stereo PCM samples from the core over a valid/ready handshake into a small FIFO. Releases exactly one sample pair per output-rate tick (48 or 96 kHz, derived fractionally from `clk`). Handles priming, underrun recovery and a click-free soft-mute ramp, so `audio_out` always sees a steady, rate-correct sample stream.

## Interface
Parameters:
- `CLK_RATE`, default 50000000: `clk` frequency in Hz; must be at least 2× 96000.
- `FIFO_DEPTH`, default 8: FIFO entries; power of 2, ≥ 4.

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: reset, asynchronous and active-low.
- `sample_rate` in 1: 0 = 48 kHz, 1 = 96 kHz output tick rate.
- `in_valid` in 1: source sample pair valid.
- `in_ready` out 1: FIFO can accept.
- `in_left`, `in_right` in 16: signed PCM.
- `mute` in 1: request soft mute (level).
- `out_left`, `out_right` out 16: signed PCM to `audio_out` (registered).
- `out_strobe` out 1: 1-cycle pulse when outputs update.
- `underrun` out 1: 1-cycle pulse on a tick with empty FIFO in RUN.
- `level` out $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- Tick generator: 32-bit accumulator `acc`.
  - Each cycle, `acc += (sample_rate ? 96000 : 48000)`.
  - If the result is ≥ `CLK_RATE`, subtract `CLK_RATE` and assert internal `tick` for that cycle.
  - `acc` is never cleared except by reset. A `sample_rate` change takes effect on the next accumulation, with no phase reset.
- FIFO:
  - Push when `in_valid && in_ready`. `in_ready = (level < FIFO_DEPTH)`, derived from the registered `level`, so a push is refused when full even if a pop occurs in the same cycle.
  - Pointers wrap modulo `FIFO_DEPTH`. `level` counts 0..`FIFO_DEPTH`.
  - Simultaneous push and pop leaves `level` unchanged.
- State machine (2 states):
  - PRIME (reset state): no pops. On `tick`, output the held sample pair (zero after reset) scaled by gain, and pulse `out_strobe`. Go to RUN when `level ≥ FIFO_DEPTH/2`; the check is made every cycle.
  - RUN, on `tick` with `level > 0`: pop the head, output it scaled by gain, pulse `out_strobe`, and latch it as the held pair.
  - RUN, on `tick` with `level == 0`: output the held pair scaled, pulse `out_strobe` and `underrun`, and go to PRIME.
- Gain: 5-bit `gain`, range 0..16, reset value 0.
  - On each `tick`: if `mute` = 1 and `gain` > 0, `gain` -= 1. If `mute` = 0 and `gain` < 16, `gain` += 1.
  - The sample output on a tick uses the pre-update `gain`.
  - Scaling: `out = (sample * gain) >>> 4`, signed 21-bit product with arithmetic shift. `gain` = 16 gives exact pass-through; `gain` = 0 gives 0.
- Reset mid-operation: all state is cleared immediately (asynchronous). FIFO contents are discarded and the block returns to PRIME.

## Timing
- Reset values:
  - `out_left`/`out_right` = 0, `out_strobe` = 0, `underrun` = 0, `level` = 0.
  - `in_ready` = 1, state PRIME, `gain` = 0, `acc` = 0, held pair = 0.
- `tick` is combinational from `acc` in cycle T. `out_*`, `out_strobe` and `underrun` update at the T+1 clock edge (1-cycle latency).
- `level` reflects a push or pop one cycle after the handshake or tick.
- Tick spacing is `CLK_RATE/rate` cycles, with fractional spacing dithered by the accumulator. Long-run average error is 0.
- A full soft-mute ramp takes 16 ticks: 333 µs at 48 kHz.
- Minimum push-to-output latency is the PRIME fill to `FIFO_DEPTH/2` plus up to one tick period.

## Test plan
- Tick rate, `CLK_RATE`=480000:
  - `sample_rate`=0 → `out_strobe` every 10 cycles exactly.
  - Switch to 1 → every 5 cycles. No missed or double strobe across the switch.
- Priming and order, `FIFO_DEPTH`=8:
  - Push 3 pairs → outputs stay 0 and `level`=3.
  - 4th push → RUN. Subsequent strobes present the pairs in push order.
- Pass-through: `mute`=0 for ≥16 ticks, push 0x7FFF/0x8000 → `out_left`=0x7FFF, `out_right`=0x8000 exactly.
- Underrun:
  - Stop pushing in RUN → on the first empty tick, `underrun` pulses once and the last pair repeats. The state stays PRIME (no further `underrun`) until `level` reaches 4.
- Full/backpressure:
  - With ticks stalled, hold `in_valid` → `level` reaches 8 and `in_ready`=0. A 9th sample is not accepted.
  - Simultaneous push and pop at `level`=5 → `level` stays 5.
- Soft mute with `gain`=16 and constant input 0x4000:
  - Assert `mute` → successive outputs are 0x4000, 0x3C00, 0x3800, … down to 0 after 16 ticks.
  - Deassert → outputs ramp back up to 0x4000.
  - Async reset mid-ramp → all outputs are 0 immediately.
